// File: rtl/stamp_counter_regs_pkg.sv
// Shared constants for the timestamp counter register slave: word offsets, CTRL bits,
// handshake states and the unmapped-address read value.
package stamp_counter_regs_pkg;

  localparam int unsigned COUNTER_REG_ADDR_WIDTH = 4;

  localparam logic [31:0] ADDR_CTRL    = 32'd0;
  localparam logic [31:0] ADDR_CNT_LO  = 32'd1;
  localparam logic [31:0] ADDR_CNT_HI  = 32'd2;
  localparam logic [31:0] ADDR_LOAD_LO = 32'd3;
  localparam logic [31:0] ADDR_LOAD_HI = 32'd4;
  localparam logic [31:0] ADDR_CAP_LO  = 32'd5;
  localparam logic [31:0] ADDR_CAP_HI  = 32'd6;
  localparam logic [31:0] ADDR_CAP_CNT = 32'd7;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAck     = 2'd1,
    StWaitRel = 2'd2
  } hs_state_e;

endpackage

// File: rtl/stamp_counter_core.sv
// 64-bit free-running timestamp counter with clear/preload/enable control and an
// external-event capture register plus wrapping event count.
module stamp_counter_core
  import stamp_counter_regs_pkg::*;
#(
  parameter logic [63:0] INC_STEP = 64'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_wr,
  input  logic        load_lo_wr,
  input  logic        load_hi_wr,
  input  logic [31:0] wr_data,
  input  logic        capture_evt,
  output logic [63:0] cnt,
  output logic        enable,
  output logic [63:0] cap,
  output logic [31:0] cap_cnt
);

  logic [63:0] cnt_q, cnt_d;
  logic        enable_q, enable_d;
  logic [31:0] load_lo_q, load_lo_d;
  logic [63:0] cap_q, cap_d;
  logic [31:0] cap_cnt_q, cap_cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    enable_d  = enable_q;
    load_lo_d = load_lo_q;
    cap_d     = cap_q;
    cap_cnt_d = cap_cnt_q;

    if (ctrl_wr) begin
      enable_d = wr_data[CTRL_ENABLE_BIT];
    end
    if (load_lo_wr) begin
      load_lo_d = wr_data;
    end

    // Clear beats a load commit, which beats the increment; the increment uses the
    // enable that was in force before this cycle's CTRL write.
    if (ctrl_wr && wr_data[CTRL_CLEAR_BIT]) begin
      cnt_d = 64'd0;
    end else if (load_hi_wr) begin
      cnt_d = {wr_data, load_lo_q};
    end else if (enable_q) begin
      cnt_d = cnt_q + INC_STEP;
    end

    // Capture sees the pre-update counter, so a coincident clear/load is not visible.
    if (capture_evt) begin
      cap_d     = cnt_q;
      cap_cnt_d = cap_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 64'd0;
      enable_q  <= 1'b0;
      load_lo_q <= 32'd0;
      cap_q     <= 64'd0;
      cap_cnt_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      load_lo_q <= load_lo_d;
      cap_q     <= cap_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign enable  = enable_q;
  assign cap     = cap_q;
  assign cap_cnt = cap_cnt_q;

endmodule

// File: rtl/stamp_counter_regs.sv
// Register-bus slave exposing the timestamp counter: req/ack handshake FSM, address
// decode, atomic LO/HI read shadow and registered read data.
module stamp_counter_regs
  import stamp_counter_regs_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = COUNTER_REG_ADDR_WIDTH,
  parameter logic [63:0] INC_STEP       = 64'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      counter_reg_req,
  input  logic                      counter_reg_rd_wr_L,
  input  logic [REG_ADDR_WIDTH-1:0] counter_reg_addr,
  input  logic [31:0]               counter_reg_wr_data,
  output logic                      counter_reg_ack,
  output logic [31:0]               counter_reg_rd_data,
  input  logic                      capture_evt,
  output logic [63:0]               stamp_counter
);

  hs_state_e   state_q, state_d;
  logic        ack_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rd_mux;
  logic [31:0] addr_word;
  logic        access, rd_en, wr_en;
  logic        ctrl_wr, load_lo_wr, load_hi_wr;
  logic [63:0] cnt;
  logic        enable;
  logic [63:0] cap;
  logic [31:0] cap_cnt;

  assign addr_word = 32'(counter_reg_addr);

  // Accesses execute only on the IDLE->ACK transition, so a lingering req never repeats one.
  assign access     = (state_q == StIdle) && counter_reg_req;
  assign rd_en      = access && counter_reg_rd_wr_L;
  assign wr_en      = access && !counter_reg_rd_wr_L;
  assign ctrl_wr    = wr_en && (addr_word == ADDR_CTRL);
  assign load_lo_wr = wr_en && (addr_word == ADDR_LOAD_LO);
  assign load_hi_wr = wr_en && (addr_word == ADDR_LOAD_HI);

  stamp_counter_core #(
    .INC_STEP (INC_STEP)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .ctrl_wr     (ctrl_wr),
    .load_lo_wr  (load_lo_wr),
    .load_hi_wr  (load_hi_wr),
    .wr_data     (counter_reg_wr_data),
    .capture_evt (capture_evt),
    .cnt         (cnt),
    .enable      (enable),
    .cap         (cap),
    .cap_cnt     (cap_cnt)
  );

  always_comb begin
    rd_mux = BAD_ADDR_DATA;
    case (addr_word)
      ADDR_CTRL:    rd_mux = {31'd0, enable};
      ADDR_CNT_LO:  rd_mux = cnt[31:0];
      ADDR_CNT_HI:  rd_mux = hi_shadow_q;
      ADDR_LOAD_LO: rd_mux = 32'd0;
      ADDR_LOAD_HI: rd_mux = 32'd0;
      ADDR_CAP_LO:  rd_mux = cap[31:0];
      ADDR_CAP_HI:  rd_mux = cap[63:32];
      ADDR_CAP_CNT: rd_mux = cap_cnt;
      default:      rd_mux = BAD_ADDR_DATA;
    endcase
  end

  always_comb begin
    rd_data_d   = rd_data_q;
    hi_shadow_d = hi_shadow_q;
    if (rd_en) begin
      rd_data_d = rd_mux;
      if (addr_word == ADDR_CNT_LO) begin
        hi_shadow_d = cnt[63:32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (counter_reg_req) state_d = StAck;
      StAck:     state_d = StWaitRel;
      StWaitRel: if (!counter_reg_req) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      rd_data_q   <= 32'd0;
      hi_shadow_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ack_q       <= (state_d == StAck);
      rd_data_q   <= rd_data_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign counter_reg_ack     = ack_q;
  assign counter_reg_rd_data = rd_data_q;
  assign stamp_counter       = cnt;

endmodule

// File: tb/tb_stamp_counter_regs.sv
// Directed self-checking bench for stamp_counter_regs: register map, atomic reads,
// carry, handshake, capture, bad addresses and mid-transaction reset.
module tb_stamp_counter_regs;

  logic        clk;
  logic        reset;
  logic        counter_reg_req;
  logic        counter_reg_rd_wr_L;
  logic [3:0]  counter_reg_addr;
  logic [31:0] counter_reg_wr_data;
  logic        counter_reg_ack;
  logic [31:0] counter_reg_rd_data;
  logic        capture_evt;
  logic [63:0] stamp_counter;

  int total;
  int bad;

  stamp_counter_regs #(
    .REG_ADDR_WIDTH (4),
    .INC_STEP       (64'd1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .counter_reg_req     (counter_reg_req),
    .counter_reg_rd_wr_L (counter_reg_rd_wr_L),
    .counter_reg_addr    (counter_reg_addr),
    .counter_reg_wr_data (counter_reg_wr_data),
    .counter_reg_ack     (counter_reg_ack),
    .counter_reg_rd_data (counter_reg_rd_data),
    .capture_evt         (capture_evt),
    .stamp_counter       (stamp_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge on which
  // the slave is back in IDLE (three edges after the call for a normal access).
  task automatic bus_access(input logic rd, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    bit seen;
    seen  = 1'b0;
    rdata = 32'hxxxxxxxx;
    counter_reg_req     = 1'b1;
    counter_reg_rd_wr_L = rd;
    counter_reg_addr    = addr;
    counter_reg_wr_data = wdata;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      capture_evt = 1'b0;
      if (counter_reg_ack === 1'b1) begin
        seen  = 1'b1;
        rdata = counter_reg_rd_data;
      end
    end
    counter_reg_req = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout addr=%0d got=no_ack want=ack", addr);
    end
    @(posedge clk); #1;
    total++;
    if (counter_reg_ack !== 1'b0) begin
      bad++;
      $display("FAIL ack_single_cycle addr=%0d got=%b want=0", addr, counter_reg_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    counter_reg_req = 1'b0;
    counter_reg_rd_wr_L = 1'b1;
    counter_reg_addr = 4'd0;
    counter_reg_wr_data = 32'd0;
    capture_evt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (counter_reg_ack !== 1'b0) begin
      bad++; $display("FAIL reset_ack got=%b want=0", counter_reg_ack);
    end
    total++;
    if (counter_reg_rd_data !== 32'd0) begin
      bad++; $display("FAIL reset_rd_data got=%h want=0", counter_reg_rd_data);
    end
    total++;
    if (stamp_counter !== 64'd0) begin
      bad++; $display("FAIL reset_stamp got=%h want=0", stamp_counter);
    end
    reset = 1'b0;
    bus_access(1'b1, 4'd0, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", r); end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL reset_cap_cnt got=%h want=0", r); end
    bus_access(1'b1, 4'd2, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL reset_cnt_hi got=%h want=0", r); end
  endtask

  task automatic test_count();
    logic [31:0] lo, hi;
    // Enable lands on the executing edge; first increment one edge later.
    bus_access(1'b0, 4'd0, 32'd1, lo);
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (stamp_counter !== 64'd102) begin
      bad++; $display("FAIL count_stamp got=%0d want=102", stamp_counter);
    end
    bus_access(1'b1, 4'd1, 32'd0, lo);
    bus_access(1'b1, 4'd2, 32'd0, hi);
    total++;
    if ({hi, lo} !== 64'd102) begin
      bad++; $display("FAIL count_read got=%h want=%h", {hi, lo}, 64'd102);
    end
  endtask

  task automatic test_carry();
    logic [31:0] lo, hi, r;
    bus_access(1'b0, 4'd0, 32'd0, r);
    bus_access(1'b0, 4'd3, 32'hFFFF_FFFC, r);
    bus_access(1'b0, 4'd4, 32'h0000_0001, r);
    total++;
    if (stamp_counter !== 64'h1_FFFF_FFFC) begin
      bad++; $display("FAIL load_commit got=%h want=%h", stamp_counter, 64'h1_FFFF_FFFC);
    end
    // LO is read just before the carry, HI after it: the shadow must keep them paired.
    bus_access(1'b0, 4'd0, 32'd1, r);
    bus_access(1'b1, 4'd1, 32'd0, lo);
    bus_access(1'b1, 4'd2, 32'd0, hi);
    total++;
    if ({hi, lo} !== 64'h1_FFFF_FFFE) begin
      bad++; $display("FAIL atomic_pair got=%h want=%h", {hi, lo}, 64'h1_FFFF_FFFE);
    end
    total++;
    if (stamp_counter !== 64'h2_0000_0004) begin
      bad++; $display("FAIL carry_stamp got=%h want=%h", stamp_counter, 64'h2_0000_0004);
    end

    bus_access(1'b0, 4'd0, 32'd0, r);
    bus_access(1'b0, 4'd3, 32'hFFFF_FFF0, r);
    bus_access(1'b0, 4'd4, 32'h0000_0001, r);
    bus_access(1'b0, 4'd0, 32'd1, r);
    repeat (32) @(posedge clk);
    #1;
    total++;
    if (stamp_counter !== 64'h2_0000_0012) begin
      bad++; $display("FAIL carry32_stamp got=%h want=%h", stamp_counter, 64'h2_0000_0012);
    end
    bus_access(1'b1, 4'd1, 32'd0, lo);
    bus_access(1'b1, 4'd2, 32'd0, hi);
    total++;
    if ({hi, lo} !== 64'h2_0000_0012) begin
      bad++; $display("FAIL carry32_read got=%h want=%h", {hi, lo}, 64'h2_0000_0012);
    end
  endtask

  task automatic test_hold_req();
    logic [31:0] r;
    int acks;
    acks = 0;
    // Clear+enable with req held 4 extra cycles: a repeated execution would re-clear.
    counter_reg_req     = 1'b1;
    counter_reg_rd_wr_L = 1'b0;
    counter_reg_addr    = 4'd0;
    counter_reg_wr_data = 32'd3;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (counter_reg_ack === 1'b1) acks++;
    end
    counter_reg_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      if (counter_reg_ack === 1'b1) acks++;
    end
    total++;
    if (acks !== 1) begin bad++; $display("FAIL hold_ack_count got=%0d want=1", acks); end
    total++;
    if (stamp_counter !== 64'd6) begin
      bad++; $display("FAIL hold_single_exec got=%0d want=6", stamp_counter);
    end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL hold_cap_cnt got=%h want=0", r); end
  endtask

  task automatic test_capture();
    logic [31:0] r;
    bus_access(1'b0, 4'd0, 32'd0, r);
    bus_access(1'b0, 4'd3, 32'h0000_0123, r);
    bus_access(1'b0, 4'd4, 32'h0000_0005, r);
    capture_evt = 1'b1;
    bus_access(1'b0, 4'd0, 32'd3, r);
    total++;
    if (stamp_counter !== 64'd2) begin
      bad++; $display("FAIL clear_stamp got=%0d want=2", stamp_counter);
    end
    bus_access(1'b1, 4'd5, 32'd0, r);
    total++;
    if (r !== 32'h0000_0123) begin bad++; $display("FAIL cap_lo got=%h want=00000123", r); end
    bus_access(1'b1, 4'd6, 32'd0, r);
    total++;
    if (r !== 32'h0000_0005) begin bad++; $display("FAIL cap_hi got=%h want=00000005", r); end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd1) begin bad++; $display("FAIL cap_cnt got=%h want=1", r); end
    bus_access(1'b1, 4'd0, 32'd0, r);
    total++;
    if (r !== 32'd1) begin bad++; $display("FAIL ctrl_clear_reads0 got=%h want=1", r); end
    capture_evt = 1'b1;
    bus_access(1'b1, 4'd5, 32'd0, r);
    total++;
    if (r !== 32'h0000_0123) begin bad++; $display("FAIL cap_read_old got=%h want=00000123", r); end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL cap_cnt2 got=%h want=2", r); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] r;
    bus_access(1'b1, 4'd9, 32'd0, r);
    total++;
    if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL bad_read got=%h want=deadbeef", r); end
    bus_access(1'b0, 4'd9, 32'hFFFF_FFFF, r);
    bus_access(1'b0, 4'd7, 32'h0000_00AA, r);
    bus_access(1'b1, 4'd0, 32'd0, r);
    total++;
    if (r !== 32'd1) begin bad++; $display("FAIL bad_write_ctrl got=%h want=1", r); end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL ro_write_cap_cnt got=%h want=2", r); end
    bus_access(1'b1, 4'd3, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL load_lo_reads0 got=%h want=0", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit seen;
    seen = 1'b0;
    counter_reg_req     = 1'b1;
    counter_reg_rd_wr_L = 1'b1;
    counter_reg_addr    = 4'd1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (counter_reg_ack === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_ack_timeout got=no_ack want=ack"); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (counter_reg_ack !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ack got=%b want=0", counter_reg_ack);
    end
    total++;
    if (stamp_counter !== 64'd0) begin
      bad++; $display("FAIL mid_reset_stamp got=%h want=0", stamp_counter);
    end
    total++;
    if (counter_reg_rd_data !== 32'd0) begin
      bad++; $display("FAIL mid_reset_rd_data got=%h want=0", counter_reg_rd_data);
    end
    counter_reg_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_access(1'b1, 4'd0, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL post_reset_ctrl got=%h want=0", r); end
    bus_access(1'b1, 4'd7, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL post_reset_cap_cnt got=%h want=0", r); end
    bus_access(1'b1, 4'd5, 32'd0, r);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL post_reset_cap_lo got=%h want=0", r); end
    bus_access(1'b0, 4'd0, 32'd1, r);
    bus_access(1'b1, 4'd1, 32'd0, r);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL post_reset_count got=%h want=2", r); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_count();
    test_carry();
    test_hold_req();
    test_capture();
    test_bad_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
